control_unit: RTL and testbench

- Sequencing controller that drives every control input of the bus-based CPU datapath.
- Runs the fetch/decode/execute state machine from the IR opcode and the registered CON flag, asserting the in/out/read/write strobes cycle by cycle.
- Sits beside the datapath: consumes IR and CON, produces all bus-source, register-load, memory and ALU-control signals.

---
 rtl/cpu_ctrl_pkg.sv | 78 +++++++
 rtl/control_unit.sv | 182 ++++++++++++++++++
 tb/tb_control_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU sequencing controller: opcodes, FSM states,
// the control-word layout and opcode-class helpers.
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10101;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // Execute states are shared between classes wherever their strobes are identical;
  // the IR opcode then picks the successor.
  typedef enum logic [4:0] {
    RESET_ST, HALT,
    T0, T1, T2, T3,
    RY_T4,   // Grb,Rout,Yin      : alu3, imm, mul/div
    BY_T4,   // Grb,BAout,Yin     : ldi, ld, st
    RZ_T5,   // Grc,Rout,Zin      : alu3, mul/div
    CZ_T5,   // Cout,Zin          : imm, ldi, ld, st
    WB_T6,   // ZLOout,Gra,Rin    : alu3, imm, ldi
    MA_T6,   // ZLOout,MARin      : ld, st
    LD_T7, LD_T8, LD_T9,
    ST_T7, ST_T8,
    MD_T6, MD_T7,
    NEG_T4, NEG_T5,
    BR_T4, BR_T5, BR_T6, BR_T7,
    JR_T4, IN_T4, OUT_T4, MFHI_T4, MFLO_T4
  } state_t;

  typedef struct packed {
    logic Run;
    logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, write, IncPC;
  } ctrl_t;

  function automatic logic is_alu3(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic is_imm(input logic [OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_mem(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the bus-based CPU datapath. One state
// register; every datapath strobe is decoded from that state (plus CON in BR_T7).
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW           = 5,
  parameter int START_PC_HOLD = 1
) (
  input  logic        Clock,
  input  logic        clr_n,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        OUTPORTin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        write,
  output logic        IncPC
);

  localparam int HOLD_W = $clog2(START_PC_HOLD + 1);

  state_t            state;
  state_t            boundaryState;
  logic [HOLD_W-1:0] holdCnt;
  logic              holdDone;
  logic [OPW-1:0]    op;
  logic              unusedIrBits;
  ctrl_t             ctrl;

  assign op            = IR[31 -: OPW];
  assign unusedIrBits  = ^IR[31-OPW:0];
  assign holdDone      = (holdCnt == HOLD_W'(START_PC_HOLD));
  // Stop only matters on the edge that would otherwise start the next fetch.
  assign boundaryState = Stop ? HALT : T0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!clr_n) begin
      state   <= RESET_ST;
      holdCnt <= '0;
    end else begin
      case (state)
        RESET_ST: begin
          if (holdDone) state <= boundaryState;
          else          holdCnt <= holdCnt + 1'b1;
        end
        HALT: state <= HALT;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_alu3(op) || is_imm(op) || is_muldiv(op)) state <= RY_T4;
          else if (is_mem(op))                            state <= BY_T4;
          else begin
            case (op)
              OP_NEG, OP_NOT: state <= NEG_T4;
              OP_BR:          state <= BR_T4;
              OP_JR:          state <= JR_T4;
              OP_IN:          state <= IN_T4;
              OP_OUT:         state <= OUT_T4;
              OP_MFHI:        state <= MFHI_T4;
              OP_MFLO:        state <= MFLO_T4;
              OP_HALT:        state <= HALT;
              default:        state <= boundaryState;
            endcase
          end
        end
        RY_T4:  state <= is_imm(op) ? CZ_T5 : RZ_T5;
        BY_T4:  state <= CZ_T5;
        RZ_T5:  state <= is_muldiv(op) ? MD_T6 : WB_T6;
        CZ_T5:  state <= (op == OP_LD || op == OP_ST) ? MA_T6 : WB_T6;
        MA_T6:  state <= (op == OP_ST) ? ST_T7 : LD_T7;
        LD_T7:  state <= LD_T8;
        LD_T8:  state <= LD_T9;
        ST_T7:  state <= ST_T8;
        MD_T6:  state <= MD_T7;
        NEG_T4: state <= NEG_T5;
        BR_T4:  state <= BR_T5;
        BR_T5:  state <= BR_T6;
        BR_T6:  state <= BR_T7;
        WB_T6, LD_T9, ST_T8, MD_T7, NEG_T5, BR_T7,
        JR_T4, IN_T4, OUT_T4, MFHI_T4, MFLO_T4:
                state <= boundaryState;
        default: state <= RESET_ST;
      endcase
    end
  end

  // NOTE: clearing the whole control word first keeps this block free of
  // latches and makes every strobe not named for a state read as 0.
  always_comb begin
    ctrl = '0;
    case (state)
      T0:      begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1; end
      T1:      begin ctrl.ZLOout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; end
      T2:      begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
      T3:      begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
      RY_T4:   begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
      BY_T4:   begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1; end
      RZ_T5:   begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
      CZ_T5:   begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
      WB_T6:   begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      MA_T6:   begin ctrl.ZLOout = 1'b1; ctrl.MARin = 1'b1; end
      LD_T7:   ctrl.Read = 1'b1;
      LD_T8:   begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
      LD_T9:   begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      // Read stays low so MDR captures the bus (register data), not memory.
      ST_T7:   begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
      ST_T8:   ctrl.write = 1'b1;
      MD_T6:   begin ctrl.ZLOout = 1'b1; ctrl.LOin = 1'b1; end
      MD_T7:   begin ctrl.ZHIout = 1'b1; ctrl.HIin = 1'b1; end
      NEG_T4:  begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
      NEG_T5:  begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      BR_T4:   begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
      BR_T5:   begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
      BR_T6:   begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
      BR_T7:   begin ctrl.ZLOout = 1'b1; ctrl.PCin = CON; end
      JR_T4:   begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
      IN_T4:   begin ctrl.INPORTout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      OUT_T4:  begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OUTPORTin = 1'b1; end
      MFHI_T4: begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      MFLO_T4: begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
      default: ;
    endcase
    ctrl.Run = (state != RESET_ST) && (state != HALT);
  end

  assign Run       = ctrl.Run;
  assign HIin      = ctrl.HIin;
  assign LOin      = ctrl.LOin;
  assign PCin      = ctrl.PCin;
  assign MDRin     = ctrl.MDRin;
  assign Zin       = ctrl.Zin;
  assign Yin       = ctrl.Yin;
  assign MARin     = ctrl.MARin;
  assign IRin      = ctrl.IRin;
  assign CONin     = ctrl.CONin;
  assign OUTPORTin = ctrl.OUTPORTin;
  assign HIout     = ctrl.HIout;
  assign LOout     = ctrl.LOout;
  assign ZHIout    = ctrl.ZHIout;
  assign ZLOout    = ctrl.ZLOout;
  assign PCout     = ctrl.PCout;
  assign MDRout    = ctrl.MDRout;
  assign INPORTout = ctrl.INPORTout;
  assign Cout      = ctrl.Cout;
  assign Gra       = ctrl.Gra;
  assign Grb       = ctrl.Grb;
  assign Grc       = ctrl.Grc;
  assign Rin       = ctrl.Rin;
  assign Rout      = ctrl.Rout;
  assign BAout     = ctrl.BAout;
  assign Read      = ctrl.Read;
  assign write     = ctrl.write;
  assign IncPC     = ctrl.IncPC;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: the driver queues the control word
// expected in each cycle, and a negedge monitor compares it with the DUT.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        clr_n, CON, Stop;
  logic [31:0] IR;
  logic Run, HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC;

  control_unit #(.OPW(5), .START_PC_HOLD(1)) dut (
    .Clock(Clock), .clr_n(clr_n), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .write(write), .IncPC(IncPC)
  );

  always #5 Clock = ~Clock;

  typedef logic [27:0] vec_t;
  localparam vec_t M_IncPC = 28'd1 << 0,  M_write  = 28'd1 << 1,  M_Read   = 28'd1 << 2;
  localparam vec_t M_BAout = 28'd1 << 3,  M_Rout   = 28'd1 << 4,  M_Rin    = 28'd1 << 5;
  localparam vec_t M_Grc   = 28'd1 << 6,  M_Grb    = 28'd1 << 7,  M_Gra    = 28'd1 << 8;
  localparam vec_t M_Cout  = 28'd1 << 9,  M_INPORTout = 28'd1 << 10, M_MDRout = 28'd1 << 11;
  localparam vec_t M_PCout = 28'd1 << 12, M_ZLOout = 28'd1 << 13, M_ZHIout = 28'd1 << 14;
  localparam vec_t M_LOout = 28'd1 << 15, M_HIout  = 28'd1 << 16, M_OUTPORTin = 28'd1 << 17;
  localparam vec_t M_CONin = 28'd1 << 18, M_IRin   = 28'd1 << 19, M_MARin  = 28'd1 << 20;
  localparam vec_t M_Yin   = 28'd1 << 21, M_Zin    = 28'd1 << 22, M_PCin   = 28'd1 << 23;
  localparam vec_t M_MDRin = 28'd1 << 24, M_LOin   = 28'd1 << 25, M_HIin   = 28'd1 << 26;
  localparam vec_t R       = 28'd1 << 27;

  vec_t obs;
  assign obs = {Run, HIin, LOin, MDRin, PCin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
                HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
                Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC};

  typedef struct {
    vec_t  exp;
    string tag;
  } item_t;
  item_t expQ[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%07h expected=%07h", tag, got, exp);
    end
  endtask

  always @(negedge Clock) begin
    item_t it;
    if (expQ.size() != 0) begin
      it = expQ.pop_front();
      check(it.tag, obs, it.exp);
    end
  end

  // Waits for the next rising edge and queues what the cycle it starts must show.
  task automatic cyc(input vec_t e, input string tag);
    item_t it;
    @(posedge Clock);
    #1;
    it.exp = e;
    it.tag = tag;
    expQ.push_back(it);
  endtask

  // IR is loaded by the datapath at the end of T3, so present it during T2.
  task automatic fetch(input logic [31:0] ir, input string nm);
    cyc(R | M_PCout | M_MARin | M_IncPC | M_Zin, {nm, ".T0"});
    cyc(R | M_ZLOout | M_PCin | M_Read, {nm, ".T1"});
    cyc(R | M_Read | M_MDRin, {nm, ".T2"});
    IR = ir;
    cyc(R | M_MDRout | M_IRin, {nm, ".T3"});
  endtask

  task automatic doReset(input int n);
    clr_n = 1'b0;
    for (int i = 0; i < n; i++) cyc('0, "rst");
    clr_n = 1'b1;
    cyc('0, "hold");
  endtask

  task automatic oneExec(input logic [31:0] ir, input string nm, input vec_t t4);
    fetch(ir, nm);
    cyc(R | t4, {nm, ".T4"});
  endtask

  initial begin
    clr_n = 1'b0;
    Stop  = 1'b0;
    CON   = 1'b0;
    IR    = 32'h0;
    doReset(2);

    fetch(32'h00800075, "ld");
    cyc(R | M_Grb | M_BAout | M_Yin, "ld.T4");
    cyc(R | M_Cout | M_Zin, "ld.T5");
    cyc(R | M_ZLOout | M_MARin, "ld.T6");
    cyc(R | M_Read, "ld.T7");
    cyc(R | M_Read | M_MDRin, "ld.T8");
    cyc(R | M_MDRout | M_Gra | M_Rin, "ld.T9");

    // Reset in the middle of a second ld aborts it at once.
    fetch(32'h00800075, "ldAbort");
    cyc(R | M_Grb | M_BAout | M_Yin, "ldAbort.T4");
    cyc(R | M_Cout | M_Zin, "ldAbort.T5");
    doReset(3);

    fetch(32'h1A920000, "add");
    cyc(R | M_Grb | M_Rout | M_Yin, "add.T4");
    cyc(R | M_Grc | M_Rout | M_Zin, "add.T5");
    cyc(R | M_ZLOout | M_Gra | M_Rin, "add.T6");

    fetch(32'h11000090, "st");
    cyc(R | M_Grb | M_BAout | M_Yin, "st.T4");
    cyc(R | M_Cout | M_Zin, "st.T5");
    cyc(R | M_ZLOout | M_MARin, "st.T6");
    cyc(R | M_Gra | M_Rout | M_MDRin, "st.T7");
    cyc(R | M_write, "st.T8");

    CON = 1'b1;
    fetch(32'h98000000, "brT");
    cyc(R | M_Gra | M_Rout | M_CONin, "brT.T4");
    cyc(R | M_PCout | M_Yin, "brT.T5");
    cyc(R | M_Cout | M_Zin, "brT.T6");
    cyc(R | M_ZLOout | M_PCin, "brT.T7");

    // CON high early but low in T7: only the T7 value may steer PCin.
    fetch(32'h98000000, "brF");
    cyc(R | M_Gra | M_Rout | M_CONin, "brF.T4");
    cyc(R | M_PCout | M_Yin, "brF.T5");
    cyc(R | M_Cout | M_Zin, "brF.T6");
    CON = 1'b0;
    cyc(R | M_ZLOout, "brF.T7");

    fetch(32'h60000000, "addi");
    cyc(R | M_Grb | M_Rout | M_Yin, "addi.T4");
    cyc(R | M_Cout | M_Zin, "addi.T5");
    cyc(R | M_ZLOout | M_Gra | M_Rin, "addi.T6");

    fetch(32'h08000000, "ldi");
    cyc(R | M_Grb | M_BAout | M_Yin, "ldi.T4");
    cyc(R | M_Cout | M_Zin, "ldi.T5");
    cyc(R | M_ZLOout | M_Gra | M_Rin, "ldi.T6");

    // A Stop pulse that is gone before the boundary must be ignored.
    fetch(32'h80000000, "mul");
    cyc(R | M_Grb | M_Rout | M_Yin, "mul.T4");
    Stop = 1'b1;
    cyc(R | M_Grc | M_Rout | M_Zin, "mul.T5");
    Stop = 1'b0;
    cyc(R | M_ZLOout | M_LOin, "mul.T6");
    cyc(R | M_ZHIout | M_HIin, "mul.T7");

    fetch(32'h90000000, "not");
    cyc(R | M_Grb | M_Rout | M_Zin, "not.T4");
    cyc(R | M_ZLOout | M_Gra | M_Rin, "not.T5");

    oneExec(32'hA8000000, "jr",   M_Gra | M_Rout | M_PCin);
    oneExec(32'hB0000000, "in",   M_INPORTout | M_Gra | M_Rin);
    oneExec(32'hB8000000, "out",  M_Gra | M_Rout | M_OUTPORTin);
    oneExec(32'hC8000000, "mfhi", M_HIout | M_Gra | M_Rin);
    oneExec(32'hC0000000, "mflo", M_LOout | M_Gra | M_Rin);
    fetch(32'hD0000000, "nop");
    fetch(32'hA0000000, "illegal");

    fetch(32'hD8000000, "halt");
    for (int i = 0; i < 20; i++) cyc('0, "haltOp");

    doReset(1);
    fetch(32'h1A920000, "addStop");
    cyc(R | M_Grb | M_Rout | M_Yin, "addStop.T4");
    Stop = 1'b1;
    cyc(R | M_Grc | M_Rout | M_Zin, "addStop.T5");
    cyc(R | M_ZLOout | M_Gra | M_Rin, "addStop.T6");
    for (int i = 0; i < 20; i++) cyc('0, "stopHalt");
    Stop = 1'b0;

    @(negedge Clock);
    #1;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
